// File: rtl/rsa_io_bridge.sv
// rtl/rsa_io_bridge.sv - core data-side bridge: RAM/IO decode, input buffer, result FIFO, run FSM
module rsa_io_bridge #(
   parameter logic [31:0] IO_BASE   = 32'h0000_0400,
   parameter int          IN_DEPTH  = 8,
   parameter int          OUT_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   input  logic        cpu_we,
   input  logic        cpu_re,
   output logic [31:0] cpu_rdata,
   input  logic [31:0] ram_rdata,
   output logic        ram_we,
   input  logic        host_in_valid,
   input  logic [31:0] host_in_data,
   output logic        host_in_ready,
   input  logic        host_go,
   output logic        cpu_start,
   output logic        res_valid,
   output logic [31:0] res_data,
   input  logic        res_ready,
   output logic        busy,
   output logic        done
);

   localparam int IN_AW  = $clog2(IN_DEPTH);
   localparam int IN_CW  = IN_AW + 1;
   localparam int OUT_AW = $clog2(OUT_DEPTH);
   localparam int OUT_CW = OUT_AW + 1;
   localparam logic [IN_CW-1:0]  IN_FULL_CNT  = IN_CW'(IN_DEPTH);
   localparam logic [OUT_CW-1:0] OUT_FULL_CNT = OUT_CW'(OUT_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [31:0]       r_in_mem [IN_DEPTH];
   logic [IN_AW-1:0]  r_in_wptr, r_in_rptr;
   logic [IN_CW-1:0]  r_in_cnt;
   logic [31:0]       r_out_mem [OUT_DEPTH];
   logic [OUT_AW-1:0] r_out_wptr, r_out_rptr;
   logic [OUT_CW-1:0] r_out_cnt;
   logic              r_ovf;
   logic              r_cpu_start;

   logic        w_io_hit;
   logic [1:0]  w_off;
   logic        w_in_empty, w_in_full, w_out_empty, w_out_full;
   logic        w_in_push, w_in_pop, w_out_wr, w_out_push, w_out_pop;
   logic        w_done_st, w_start_run;
   logic [31:0] w_io_rdata;

   assign w_io_hit    = (cpu_addr[31:4] == IO_BASE[31:4]);
   assign w_off       = cpu_addr[3:2];
   assign w_in_empty  = (r_in_cnt == '0);
   assign w_in_full   = (r_in_cnt == IN_FULL_CNT);
   assign w_out_empty = (r_out_cnt == '0);
   assign w_out_full  = (r_out_cnt == OUT_FULL_CNT);

   assign w_in_push   = host_in_valid & host_in_ready;
   assign w_in_pop    = cpu_re & w_io_hit & (w_off == 2'd1) & ~w_in_empty;
   assign w_out_wr    = cpu_we & w_io_hit & (w_off == 2'd2) & (r_state == S_RUN);
   assign w_out_push  = w_out_wr & ~w_out_full;
   assign w_out_pop   = res_valid & res_ready;
   assign w_done_st   = cpu_we & w_io_hit & (w_off == 2'd3) & (r_state == S_RUN);
   assign w_start_run = (r_state == S_IDLE) & host_go & ~w_in_empty;

   assign ram_we        = cpu_we & ~w_io_hit;
   assign host_in_ready = (r_state == S_IDLE) & ~w_in_full;
   assign res_valid     = ~w_out_empty;
   assign res_data      = r_out_mem[r_out_rptr];
   assign busy          = (r_state == S_RUN);
   assign done          = (r_state == S_DONE);
   assign cpu_start     = r_cpu_start;

   // Input buffer storage; contents need no reset because the count gates every read
   always_ff @(posedge clk) begin
      if (w_in_push) r_in_mem[r_in_wptr] <= host_in_data;
   end

   // Input buffer pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_in_wptr <= '0;
         r_in_rptr <= '0;
         r_in_cnt  <= '0;
      end else begin
         if (w_in_push) r_in_wptr <= r_in_wptr + IN_AW'(1);
         if (w_in_pop)  r_in_rptr <= r_in_rptr + IN_AW'(1);
         r_in_cnt <= r_in_cnt + IN_CW'(w_in_push) - IN_CW'(w_in_pop);
      end
   end

   // Result FIFO storage
   always_ff @(posedge clk) begin
      if (w_out_push) r_out_mem[r_out_wptr] <= cpu_wdata;
   end

   // Result FIFO pointers, occupancy and sticky overflow (cleared when a new run starts)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_wptr <= '0;
         r_out_rptr <= '0;
         r_out_cnt  <= '0;
         r_ovf      <= 1'b0;
      end else begin
         if (w_out_push) r_out_wptr <= r_out_wptr + OUT_AW'(1);
         if (w_out_pop)  r_out_rptr <= r_out_rptr + OUT_AW'(1);
         r_out_cnt <= r_out_cnt + OUT_CW'(w_out_push) - OUT_CW'(w_out_pop);
         if (w_start_run)
            r_ovf <= 1'b0;
         else if (w_out_wr & w_out_full)
            r_ovf <= 1'b1;
      end
   end

   // Run FSM state register; cpu_start is registered from the next state so it tracks RUN glitch-free
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_cpu_start <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_cpu_start <= (w_next == S_RUN);
      end
   end

   // Run FSM next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start_run) w_next = S_RUN;
         S_RUN:   if (w_done_st) w_next = S_DONE;
         S_DONE:  if (w_out_empty & ~host_go) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // I/O window read mux; reads have no side effect unless cpu_re pops IN_POP
   always_comb begin
      w_io_rdata = 32'd0;
      case (w_off)
         2'd0:    w_io_rdata = {28'd0, r_ovf, w_out_full, w_in_empty, busy};
         2'd1:    w_io_rdata = w_in_empty ? 32'd0 : r_in_mem[r_in_rptr];
         default: w_io_rdata = 32'd0;
      endcase
   end

   assign cpu_rdata = w_io_hit ? w_io_rdata : ram_rdata;

endmodule

// File: tb/tb_rsa_io_bridge.sv
// tb/tb_rsa_io_bridge.sv - self-checking bench for rsa_io_bridge against a queue-based model
module tb_rsa_io_bridge;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, ram_rdata, host_in_data, res_data;
   logic        cpu_we, cpu_re, ram_we, host_in_valid, host_in_ready, host_go;
   logic        cpu_start, res_valid, res_ready, busy, done;

   always #5 clk = ~clk;

   rsa_io_bridge dut (
      .clk(clk), .reset(reset),
      .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
      .cpu_rdata(cpu_rdata), .ram_rdata(ram_rdata), .ram_we(ram_we),
      .host_in_valid(host_in_valid), .host_in_data(host_in_data), .host_in_ready(host_in_ready),
      .host_go(host_go), .cpu_start(cpu_start),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .busy(busy), .done(done)
   );

   localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

   int          n_vec = 0;
   int          n_bad = 0;
   logic [31:0] mq_in[$];
   logic [31:0] mq_out[$];
   int          m_mode = M_IDLE;
   bit          m_ovf = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_idle();
      cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_we = 1'b0; cpu_re = 1'b0;
      ram_rdata = $urandom; host_in_valid = 1'b0; host_in_data = 32'd0;
      host_go = 1'b0; res_ready = 1'b0;
   endtask

   // Inputs are already driven (just after negedge): check outputs, advance the model, clock once.
   task automatic cycle();
      bit          hit, rdy;
      logic [1:0]  off;
      logic [31:0] exp_rd;
      int          in_n, out_n;
      #1;
      hit   = (cpu_addr[31:4] == 28'h000_0040);
      off   = cpu_addr[3:2];
      in_n  = mq_in.size();
      out_n = mq_out.size();
      rdy   = (m_mode == M_IDLE) && (in_n < 8);
      if (!hit) exp_rd = ram_rdata;
      else if (off == 2'd0)
         exp_rd = {28'd0, m_ovf, (out_n == 16), (in_n == 0), (m_mode == M_RUN)};
      else if (off == 2'd1) exp_rd = (in_n > 0) ? mq_in[0] : 32'd0;
      else exp_rd = 32'd0;
      chk("cpu_rdata", cpu_rdata, exp_rd);
      chk("ram_we", {31'd0, ram_we}, {31'd0, cpu_we & ~hit});
      chk("host_in_ready", {31'd0, host_in_ready}, {31'd0, rdy});
      chk("cpu_start", {31'd0, cpu_start}, {31'd0, m_mode == M_RUN});
      chk("busy", {31'd0, busy}, {31'd0, m_mode == M_RUN});
      chk("done", {31'd0, done}, {31'd0, m_mode == M_DONE});
      chk("res_valid", {31'd0, res_valid}, {31'd0, out_n > 0});
      if (out_n > 0) chk("res_data", res_data, mq_out[0]);
      if (cpu_re && hit && off == 2'd1 && in_n > 0) void'(mq_in.pop_front());
      if (host_in_valid && rdy) mq_in.push_back(host_in_data);
      if (res_ready && out_n > 0) void'(mq_out.pop_front());
      if (cpu_we && hit && off == 2'd2 && m_mode == M_RUN) begin
         if (out_n == 16) m_ovf = 1'b1;
         else mq_out.push_back(cpu_wdata);
      end
      case (m_mode)
         M_IDLE: if (host_go && in_n > 0) begin m_mode = M_RUN; m_ovf = 1'b0; end
         M_RUN:  if (cpu_we && hit && off == 2'd3) m_mode = M_DONE;
         default: if (out_n == 0 && !host_go) m_mode = M_IDLE;
      endcase
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asynchronous reset asserted mid-cycle; outputs must clear before any clock edge.
   task automatic mid_reset();
      drive_idle();
      cpu_addr = 32'h0000_0400;
      reset = 1'b1;
      #1;
      chk("rst_cpu_start", {31'd0, cpu_start}, 32'd0);
      chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, host_in_ready}, 32'd1);
      chk("rst_status", cpu_rdata, 32'h2);
      mq_in.delete(); mq_out.delete(); m_mode = M_IDLE; m_ovf = 1'b0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic push_host(input logic [31:0] d);
      drive_idle(); host_in_valid = 1'b1; host_in_data = d; cycle();
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      drive_idle(); cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d; cycle();
   endtask

   task automatic pulse_go();
      drive_idle(); host_go = 1'b1; cycle();
   endtask

   task automatic drain_all();
      for (int k = 0; k < 40 && mq_out.size() > 0; k++) begin
         drive_idle(); res_ready = 1'b1; cycle();
      end
      chk("drain_empty", {31'd0, res_valid}, 32'd0);
   endtask

   initial begin
      logic [31:0] pop_exp [3];
      int          r, k;
      pop_exp[0] = 32'd5; pop_exp[1] = 32'd7; pop_exp[2] = 32'd11;
      drive_idle();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      drive_idle(); cpu_addr = 32'h0000_0400;
      #1 chk("init_status", cpu_rdata, 32'h2);
      cycle();

      // load 5,7,11 and start a run
      push_host(32'd5); push_host(32'd7); push_host(32'd11);
      pulse_go();
      drive_idle();
      #1;
      chk("go_busy", {31'd0, busy}, 32'd1);
      chk("go_cpu_start", {31'd0, cpu_start}, 32'd1);
      cycle();
      for (int i = 0; i < 4; i++) begin
         drive_idle(); cpu_re = 1'b1; cpu_addr = 32'h0000_0404;
         #1 chk("in_pop", cpu_rdata, (i < 3) ? pop_exp[i] : 32'd0);
         cycle();
      end
      // three results queued, then reset mid-run
      for (int i = 0; i < 3; i++) store(32'h0000_0408, 32'h50 + i);
      mid_reset();
      cycle();

      // address decode
      push_host(32'd42);
      pulse_go();
      drive_idle(); cpu_we = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEAD;
      #1 chk("ram_store_we", {31'd0, ram_we}, 32'd1);
      cycle();
      drive_idle(); cpu_we = 1'b1; cpu_addr = 32'h0000_0408; cpu_wdata = 32'hBEEF;
      #1 chk("io_store_we", {31'd0, ram_we}, 32'd0);
      cycle();
      chk("io_push_data", res_data, 32'hBEEF);
      drive_idle(); cpu_re = 1'b1; cpu_addr = 32'h0000_0404;
      #1 chk("io_load", cpu_rdata, 32'd42);
      cycle();
      drive_idle(); cpu_re = 1'b1; cpu_addr = 32'h0000_0010; ram_rdata = 32'h1234_5678;
      #1 chk("ram_load", cpu_rdata, 32'h1234_5678);
      cycle();
      drain_all();

      // overflow: 17 pushes without draining
      for (int i = 0; i < 17; i++) store(32'h0000_0408, 32'd100 + i);
      drive_idle(); cpu_addr = 32'h0000_0400;
      #1 chk("ovf_status", cpu_rdata & 32'hD, 32'hD);
      cycle();
      for (int i = 0; i < 16; i++) begin
         drive_idle(); res_ready = 1'b1;
         #1 chk("ovf_drain", res_data, 32'd100 + i);
         cycle();
      end
      chk("ovf_lost", {31'd0, res_valid}, 32'd0);

      // simultaneous push/pop at depth 4 across pointer wrap
      for (int i = 0; i < 4; i++) store(32'h0000_0408, 32'd300 + i);
      for (int i = 0; i < 40; i++) begin
         drive_idle(); cpu_we = 1'b1; cpu_addr = 32'h0000_0408; cpu_wdata = 32'd200 + i;
         res_ready = 1'b1;
         #1 chk("sim_order", res_data, (i < 4) ? 32'd300 + i : 32'd196 + i);
         cycle();
      end
      for (int i = 0; i < 4; i++) begin
         drive_idle(); res_ready = 1'b1;
         #1 chk("sim_tail", res_data, 32'd236 + i);
         cycle();
      end
      chk("sim_empty", {31'd0, res_valid}, 32'd0);

      // completion
      store(32'h0000_0408, 32'hA1);
      store(32'h0000_0408, 32'hA2);
      store(32'h0000_040C, 32'd0);
      drive_idle();
      #1;
      chk("done_flag", {31'd0, done}, 32'd1);
      chk("done_start", {31'd0, cpu_start}, 32'd0);
      cycle();
      k = 0;
      while (done && k < 10) begin
         drive_idle(); res_ready = 1'b1; cycle(); k++;
      end
      chk("done_to_idle", {31'd0, done}, 32'd0);
      pulse_go();
      drive_idle();
      #1 chk("go_empty_idle", {31'd0, busy}, 32'd0);
      cycle();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            mid_reset();
            continue;
         end
         drive_idle();
         host_in_valid = $urandom_range(0, 1);
         host_in_data  = $urandom;
         host_go       = ($urandom_range(0, 15) == 0);
         res_ready     = $urandom_range(0, 1);
         cpu_wdata     = $urandom;
         r = $urandom_range(0, 3);
         if (r == 0) cpu_we = 1'b1;
         else if (r == 1) cpu_re = 1'b1;
         case ($urandom_range(0, 7))
            0, 1, 2: cpu_addr = 32'h0000_0400 | 32'($urandom_range(0, 11));
            3:       cpu_addr = 32'h0000_040C | 32'($urandom_range(0, 3));
            4:       cpu_addr = 32'h0000_0410 | 32'($urandom_range(0, 15));
            5:       cpu_addr = 32'h0000_03FC;
            default: cpu_addr = $urandom;
         endcase
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
